// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared PC/instruction constants and fetch FSM encoding
package inst_fetch_pkg;
    localparam int PC_W = 32;
    localparam int INST_W = 32;
    localparam logic [PC_W-1:0] PC_STEP = 32'd4;
    localparam logic [INST_W-1:0] INST_NOP = 32'h0000_0000;
    typedef enum logic [1:0] {
        ST_FETCH,
        ST_HOLD,
        ST_SQUASH
    } fetch_state_t;
endpackage

// File: rtl/inst_fetch_if_id_reg.sv
// if_id_reg: IF/ID pipeline register with a one-word skid buffer
module if_id_reg
    import inst_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              skid_wr,
    input  logic              load,
    input  logic              load_skid,
    input  logic              flush,
    input  logic              en,
    input  logic [INST_W-1:0] fetch_data,
    input  logic [PC_W-1:0]   load_pc,
    output logic [INST_W-1:0] inst_id,
    output logic [PC_W-1:0]   pc_id,
    output logic              id_valid
);
    logic [INST_W-1:0] skid;
    // capture a fetched word that could not enter IF/ID yet
    always_ff @(posedge clk) begin
        if (rst)
            skid <= INST_NOP;
        else if (skid_wr)
            skid <= fetch_data;
    end
    // flush beats load; an enabled cycle without a load inserts a bubble
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            inst_id  <= INST_NOP;
            pc_id    <= '0;
            id_valid <= 1'b0;
        end else if (load) begin
            inst_id  <= load_skid ? skid : fetch_data;
            pc_id    <= load_pc;
            id_valid <= 1'b1;
        end else if (en) begin
            inst_id  <= INST_NOP;
            id_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: single-outstanding instruction fetch with redirect squash and IF/ID skid
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_en,
    input  logic              if_rst,
    input  logic              id_en,
    input  logic              id_rst,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_data,
    output logic [INST_W-1:0] inst_id,
    output logic [PC_W-1:0]   pc_id,
    output logic              id_valid,
    output logic              if_valid,
    output logic              fetch_stall
);
    fetch_state_t state, state_nx;
    logic [PC_W-1:0] pc, sq_addr;
    logic active, go, ack, advance, skid_wr;
    // fetch FSM state register; if_rst restarts the IF side only
    always_ff @(posedge clk) begin
        if (rst || if_rst)
            state <= ST_FETCH;
        else
            state <= state_nx;
    end
    // next state: redirects kill in-flight work, a blocked ack parks in HOLD
    always_comb begin
        state_nx = state == ST_FETCH ? (redirect_valid ? (ack ? ST_FETCH : ST_SQUASH)
                                                       : (ack && !go ? ST_HOLD : ST_FETCH))
                 : state == ST_HOLD  ? (redirect_valid || go ? ST_FETCH : ST_HOLD)
                 : ack ? ST_FETCH : ST_SQUASH;
    end
    // handshake and pipeline control decode
    always_comb begin
        active      = !rst && !if_rst;
        go          = if_en && id_en;
        imem_req    = active && state != ST_HOLD;
        imem_addr   = state == ST_SQUASH ? sq_addr : pc;
        ack         = imem_req && imem_ack;
        advance     = active && !redirect_valid && go && (state == ST_HOLD || (state == ST_FETCH && ack));
        skid_wr     = state == ST_FETCH && ack && !redirect_valid && !go;
        fetch_stall = id_en && !advance;
        if_valid    = active && state != ST_SQUASH;
    end
    // pc follows redirects first; sq_addr keeps the killed request's address stable
    always_ff @(posedge clk) begin
        if (rst || if_rst) begin
            pc      <= RESET_PC;
            sq_addr <= RESET_PC;
        end else begin
            if (redirect_valid)
                pc <= redirect_pc;
            else if (advance)
                pc <= pc + PC_STEP;
            if (state == ST_FETCH && redirect_valid && !ack)
                sq_addr <= pc;
        end
    end
    if_id_reg u_if_id (
        .clk        (clk),
        .rst        (rst),
        .skid_wr    (skid_wr),
        .load       (advance),
        .load_skid  (state == ST_HOLD),
        .flush      (id_rst),
        .en         (id_en),
        .fetch_data (imem_data),
        .load_pc    (pc + PC_STEP),
        .inst_id    (inst_id),
        .pc_id      (pc_id),
        .id_valid   (id_valid)
    );
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: randomized fetch traffic against a transaction-level model with an IF/ID scoreboard
module tb_inst_fetch;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    logic clk = 1'b0;
    logic rst = 1'b1, if_en = 1'b0, if_rst = 1'b0, id_en = 1'b0, id_rst = 1'b0;
    logic redirect_valid = 1'b0, imem_ack = 1'b0;
    logic [31:0] redirect_pc = '0, imem_data = '0;
    logic imem_req, id_valid, if_valid, fetch_stall;
    logic [31:0] imem_addr, inst_id, pc_id;
    int checks = 0, fails = 0;
    logic [64:0] exp_q[$];
    logic [31:0] m_pc = RST_PC, m_dead_addr = '0, m_inst = '0, m_pcid = '0;
    logic m_held = 1'b0, m_dead = 1'b0, m_val = 1'b0;
    logic mem_busy = 1'b0;
    logic [31:0] mem_addr = '0;
    int mem_cnt = 0;

    inst_fetch #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .if_en(if_en), .if_rst(if_rst), .id_en(id_en), .id_rst(id_rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .inst_id(inst_id), .pc_id(pc_id), .id_valid(id_valid), .if_valid(if_valid), .fetch_stall(fetch_stall)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // one clock of stimulus: drive inputs, act as memory, check IF-side outputs, advance the model
    task automatic step(input logic r, input logic ir, input logic ie, input logic de, input logic dr,
                        input logic rv, input logic [31:0] rp, input int lat);
        logic active, e_req, ack, got, deliver;
        @(negedge clk);
        rst = r; if_rst = ir; if_en = ie; id_en = de; id_rst = dr;
        redirect_valid = rv; redirect_pc = rp; imem_ack = 1'b0;
        #1;
        active = !r && !ir;
        e_req = active && !m_held;
        chk("imem_req", {31'b0, imem_req}, {31'b0, e_req});
        chk("if_valid", {31'b0, if_valid}, {31'b0, active && !m_dead});
        if (e_req) chk("imem_addr", imem_addr, m_dead ? m_dead_addr : m_pc);
        ack = 1'b0;
        if (imem_req) begin
            if (!mem_busy) begin
                mem_busy = 1'b1; mem_addr = imem_addr; mem_cnt = lat;
            end else
                chk("addr_stable", imem_addr, mem_addr);
            ack = mem_cnt == 0;
            if (ack) mem_busy = 1'b0; else mem_cnt--;
        end else
            mem_busy = 1'b0;
        imem_ack = ack;
        imem_data = ack ? mem_word(mem_addr) : $urandom;
        #1;
        got = e_req && ack;
        deliver = active && !rv && ie && de && (m_held || (got && !m_dead));
        chk("fetch_stall", {31'b0, fetch_stall}, {31'b0, de && !deliver});
        if (r || dr) begin
            m_val = 1'b0; m_inst = '0; m_pcid = '0;
        end else if (deliver) begin
            m_val = 1'b1; m_inst = mem_word(m_pc); m_pcid = m_pc + 32'd4;
        end else if (de) begin
            m_val = 1'b0; m_inst = '0;
        end
        if (!active) begin
            m_pc = RST_PC; m_held = 1'b0; m_dead = 1'b0;
        end else if (rv) begin
            if (m_dead) m_dead = !got;
            else if (!m_held && !got) begin m_dead = 1'b1; m_dead_addr = m_pc; end
            m_held = 1'b0; m_pc = rp;
        end else if (m_dead)
            m_dead = !got;
        else if (deliver) begin
            m_pc = m_pc + 32'd4; m_held = 1'b0;
        end else if (got)
            m_held = 1'b1;
        exp_q.push_back({m_val, m_inst, m_pcid});
    endtask

    task automatic run(input int n, input logic ie, input logic de, input int lat);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, ie, de, 1'b0, 1'b0, '0, lat);
    endtask

    // scoreboard monitor: every edge presents the next expected IF/ID contents
    always @(posedge clk) begin
        logic [64:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("id_valid", {31'b0, id_valid}, {31'b0, e[64]});
            chk("inst_id", inst_id, e[63:32]);
            chk("pc_id", pc_id, e[31:0]);
        end
    end

    initial begin
        step(1, 0, 1, 1, 0, 0, '0, 0);
        step(1, 0, 1, 1, 0, 0, '0, 0);
        run(6, 1, 1, 0);
        run(9, 1, 1, 3);
        run(1, 1, 1, 0);
        step(0, 0, 1, 0, 0, 0, '0, 0);
        run(2, 1, 0, 0);
        run(3, 1, 1, 0);
        step(0, 0, 1, 1, 0, 1, 32'h0000_0010, 0);
        step(0, 0, 1, 1, 0, 0, '0, 3);
        step(0, 0, 1, 1, 0, 1, 32'h0000_0040, 3);
        run(6, 1, 1, 0);
        step(0, 0, 1, 1, 1, 0, '0, 0);
        run(2, 1, 1, 2);
        step(1, 0, 1, 1, 0, 0, '0, 0);
        run(3, 1, 1, 0);
        step(0, 0, 1, 1, 0, 1, 32'hFFFF_FFF8, 0);
        run(4, 1, 1, 0);
        step(0, 0, 1, 1, 0, 1, 32'h0000_0103, 1);
        run(3, 1, 1, 1);
        step(0, 1, 1, 1, 0, 0, '0, 0);
        run(3, 1, 1, 0);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 149) == 0, $urandom_range(0, 79) == 0, $urandom_range(0, 7) != 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 11) == 0,
                 $urandom_range(0, 3) == 0 ? 32'hFFFF_FFFC : $urandom, $urandom_range(0, 3));
        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            checks++; fails++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter: RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 SHALL have port: clk  in  1  main clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  in  1  synchronous reset, active-high.
REQ-004 SHALL have port: if_en  in  1  IF stage enable from controller; 0 freezes PC.
REQ-005 SHALL have port: if_rst  in  1  IF stage reset from controller.
REQ-006 SHALL have port: id_en  in  1  IF/ID register enable from controller; 0 holds IF/ID contents.
REQ-007 SHALL have port: id_rst  in  1  IF/ID flush from controller; inserts NOP.
REQ-008 SHALL have port: redirect_valid  in  1  resolved jump/branch/JR target valid, from MEM stage.
REQ-009 SHALL have port: redirect_pc  in  32  redirect target address.
REQ-010 SHALL have ports: imem_req  out  1; imem_addr  out  32; imem_ack  in  1; imem_data  in  32.
REQ-011 SHALL have ports: inst_id  out  32; pc_id  out  32 (fetch PC + 4); id_valid  out  1.
REQ-012 SHALL have ports: if_valid  out  1 (fetch in flight, not squashed); fetch_stall  out  1.
REQ-013 Reset SHALL be synchronous, active-high, on the single clock clk.

Function
REQ-014 Instruction-memory handshake SHALL be single-outstanding: imem_req held high with imem_addr stable until the cycle imem_ack=1; variable latency of 0 or more cycles.
REQ-015 FSM SHALL have states FETCH (req high, awaiting ack), HOLD (word captured, IF/ID blocked), SQUASH (awaiting ack of killed request).
REQ-016 FETCH, ack, if_en=1, id_en=1, no redirect: SHALL load inst_id=imem_data, pc_id=pc+4, id_valid=1, pc<=pc+4; stay FETCH; new request issued next cycle.
REQ-017 FETCH, ack, id_en=0 or if_en=0: SHALL capture word into skid register, move to HOLD, imem_req=0.
REQ-018 HOLD, if_en=1, id_en=1: SHALL transfer skid word into IF/ID, pc<=pc+4, return to FETCH.
REQ-019 redirect_valid=1 SHALL set pc<=redirect_pc that cycle, overriding increment; from HOLD discard skid, go FETCH; from FETCH without ack go SQUASH; from FETCH with ack discard word, stay FETCH.
REQ-020 SQUASH SHALL keep imem_req high at old address until ack, drop data, then FETCH with redirected pc; further redirects in SQUASH update pc only.
REQ-021 id_rst=1 SHALL force inst_id=32'h0, id_valid=0 next edge, priority over load; IF-side state unaffected.
REQ-022 id_en=0 and id_rst=0 SHALL hold inst_id, pc_id, id_valid unchanged.
REQ-023 if_rst=1 SHALL act as rst for pc and FSM, leaving IF/ID untouched.
REQ-024 fetch_stall SHALL be 1 when id_en=1 and no word loaded that cycle (FETCH without ack, or SQUASH).
REQ-025 if_valid SHALL be 1 in FETCH and HOLD, 0 in SQUASH and during reset.
REQ-026 pc arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0; low two bits of redirect_pc passed unchanged.

Reset
REQ-027 On rst: pc=RESET_PC, state=FETCH, imem_req=0, inst_id=0, pc_id=0, id_valid=0, skid cleared; imem_req asserts first cycle after rst deasserts.
REQ-028 rst mid-request SHALL abandon it; memory accepts a new request when req reasserts.

Structure
REQ-029 State encodings and NOP constant SHALL live in shared package/header with existing PC_* and INST_* definitions.
REQ-030 IF/ID register with skid buffer SHALL be one sub-module: if_id_reg.

Verification
REQ-031 RESET_PC=0, ack every cycle, enables 1 -> imem_addr 0,4,8; inst_id follows imem_data one cycle later, pc_id 4,8,C.
REQ-032 Ack latency 3 cycles -> imem_addr stable 3 cycles, fetch_stall=1 for 3 cycles, id_valid=1 only after ack.
REQ-033 id_en=0 on ack at pc=8 -> HOLD, req=0; id_en=1 two cycles later -> inst_id=word@8, next addr C.
REQ-034 redirect_valid, redirect_pc=0x40 while request @0x10 waits -> ack @0x10 dropped, next imem_addr=0x40, no stale word reaches inst_id.
REQ-035 id_rst=1 with simultaneous ack -> inst_id=0, id_valid=0, pc still advances; rst mid-wait -> next request at RESET_PC.
